barrel_shift_pipe: RTL



---
 rtl/shift_pkg.sv | 24 ++
 rtl/barrel_shift_pipe_if.sv | 30 +++
 rtl/shift_stage.sv | 51 +++++
 rtl/barrel_shift_pipe.sv | 94 +++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the pipelined barrel shifter: operation encoding,
// per-stage control payload and the right-shift fill rule.
package shift_pkg;

  typedef enum logic [2:0] {
    FN_SHL = 3'b000,
    FN_SHR = 3'b001,
    FN_ROL = 3'b010,
    FN_ROR = 3'b011,
    FN_SAR = 3'b100
  } shift_fn_e;

  // Width-independent part of the stage payload; data and the remaining
  // shift count are sized by WIDTH and live in the top-level payload struct.
  typedef struct packed {
    shift_fn_e fn;
    logic      carry;
  } stage_ctl_t;

  function automatic logic fill_bit(input shift_fn_e fn, input logic msb);
    return (fn == FN_SAR) && msb;
  endfunction

endpackage

// File: rtl/barrel_shift_pipe_if.sv
// Operand/result handshake bundle between the operand-read stage, the
// barrel shifter and the ALU result mux.
interface barrel_shift_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned SCW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SCW-1:0]   in_sc;
  logic [2:0]       in_fn;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_c;
  logic             out_z;
  logic             out_n;

  modport master (
    output in_valid, in_data, in_sc, in_fn, out_ready,
    input  in_ready, out_valid, out_data, out_c, out_z, out_n
  );

  modport slave (
    input  in_valid, in_data, in_sc, in_fn, out_ready,
    output in_ready, out_valid, out_data, out_c, out_z, out_n
  );

endinterface

// File: rtl/shift_stage.sv
// One barrel-shifter stage: shift/rotate by the constant DIST when enabled,
// reporting the bit that crossed the word boundary as the new carry.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIST  = 1
) (
  input  logic             en_i,
  input  shift_fn_e        fn_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] data_o,
  output logic             carry_o
);

  localparam logic [WIDTH-1:0] HI_MASK   = ~({WIDTH{1'b1}} >> DIST);
  localparam int unsigned      LEFT_OUT  = WIDTH - DIST;
  localparam int unsigned      RIGHT_OUT = DIST - 1;

  always_comb begin
    data_o  = data_i;
    carry_o = carry_i;
    if (en_i) begin
      case (fn_i)
        FN_SHL: begin
          data_o  = data_i << DIST;
          carry_o = data_i[LEFT_OUT];
        end
        FN_SHR, FN_SAR: begin
          data_o  = (data_i >> DIST) | (fill_bit(fn_i, data_i[WIDTH-1]) ? HI_MASK : '0);
          carry_o = data_i[RIGHT_OUT];
        end
        FN_ROL: begin
          data_o  = (data_i << DIST) | (data_i >> LEFT_OUT);
          carry_o = data_i[LEFT_OUT];
        end
        FN_ROR: begin
          data_o  = (data_i >> DIST) | (data_i << LEFT_OUT);
          carry_o = data_i[RIGHT_OUT];
        end
        // Reserved encodings pass data and keep the (zero) carry.
        default: begin
          data_o  = data_i;
          carry_o = carry_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: one registered stage per shift-count bit, a
// single global stall, and z/n flags registered alongside the result.
module barrel_shift_pipe
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  input logic                flush,
  barrel_shift_pipe_if.slave bus
);

  localparam int unsigned SCW = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SCW-1:0]   sc;
    stage_ctl_t       ctl;
  } stage_pl_t;

  stage_pl_t      pl_q [SCW];
  stage_pl_t      pl_d [SCW];
  logic [SCW-1:0] vld_q;
  logic           z_q, n_q;
  logic           z_d, n_d;
  logic           stall;
  logic           unused_tail;

  assign stall        = vld_q[SCW-1] & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  for (genvar k = 0; k < SCW; k++) begin : g_stage
    stage_pl_t        st_in;
    logic [WIDTH-1:0] sh_data;
    logic             sh_carry;

    if (k == 0) begin : g_head
      assign st_in = '{data: bus.in_data, sc: bus.in_sc,
                       ctl: '{fn: shift_fn_e'(bus.in_fn), carry: 1'b0}};
    end else begin : g_body
      assign st_in = pl_q[k-1];
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_stage (
      .en_i    (st_in.sc[k]),
      .fn_i    (st_in.ctl.fn),
      .data_i  (st_in.data),
      .carry_i (st_in.ctl.carry),
      .data_o  (sh_data),
      .carry_o (sh_carry)
    );

    assign pl_d[k] = '{data: sh_data, sc: st_in.sc,
                       ctl: '{fn: st_in.ctl.fn, carry: sh_carry}};
  end

  assign z_d = (pl_d[SCW-1].data == '0);
  assign n_d = pl_d[SCW-1].data[WIDTH-1];

  // Payload registers advance on every unstalled edge, bubbles included;
  // only the valid chain distinguishes live results from stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < SCW; i++) pl_q[i] <= '0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
    end else begin
      if (flush) begin
        vld_q <= '0;
      end else if (!stall) begin
        vld_q <= {vld_q[SCW-2:0], bus.in_valid};
      end
      if (!stall) begin
        pl_q <= pl_d;
        z_q  <= z_d;
        n_q  <= n_d;
      end
    end
  end

  assign bus.out_valid = vld_q[SCW-1];
  assign bus.out_data  = pl_q[SCW-1].data;
  assign bus.out_c     = pl_q[SCW-1].ctl.carry;
  assign bus.out_z     = z_q;
  assign bus.out_n     = n_q;

  assign unused_tail = ^{pl_q[SCW-1].sc, pl_q[SCW-1].ctl.fn};

endmodule
